// File: rtl/branch_predictor_bht.sv
// -----------------------------------------------------------------------------
// branch_predictor_bht
//
// Direction and target predictor sitting beside fetch. A direct-mapped BTB
// holds, per entry, a valid bit, a PC tag, the last taken target, an
// unconditional flag and a saturating direction counter. Lookup is purely
// combinational from registered state (zero latency); training happens at the
// rising clock edge from decode-stage resolution commits. A saturating
// mispredict counter tracks commits that decode flagged as not-hit.
//
// Optional feature (macro BP_RAS_EN): a RAS_DEPTH-entry return address stack,
// pushed by committed calls and popped by committed returns. BTB entries marked
// as returns take their target from the stack top while the stack is non-empty.
// With the macro undefined there is no stack, no ret field, and
// commit_call/commit_ret are ignored.
//
// Ports:
//   clk             clock
//   resetn          asynchronous active-low reset
//   fetch_pc        PC being fetched
//   predict_pcsrc   0 = PC+4, 1 = jump
//   predict_target  predicted next PC
//   commit_valid    one resolved control-flow instruction this cycle
//   commit_pc       PC of the resolved instruction
//   commit_pcsrc    actual outcome, 0 = PC+4, 1 = jump
//   commit_target   actual target when taken
//   commit_uncond   JAL/JALR (always taken)
//   commit_call     call (RAS push)
//   commit_ret      return (RAS pop)
//   commit_hit      decode's prediction-hit flag for this instruction
//   mispredict_cnt  saturating count of commit_valid & !commit_hit
// -----------------------------------------------------------------------------
module branch_predictor_bht #(
   parameter int ENTRIES   = 64,
   parameter int TAG_BITS  = 12,
   parameter int CNT_BITS  = 2,
   parameter int RAS_DEPTH = 8
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [63:0] fetch_pc,
   output logic        predict_pcsrc,
   output logic [63:0] predict_target,
   input  logic        commit_valid,
   input  logic [63:0] commit_pc,
   input  logic        commit_pcsrc,
   input  logic [63:0] commit_target,
   input  logic        commit_uncond,
   input  logic        commit_call,
   input  logic        commit_ret,
   input  logic        commit_hit,
   output logic [31:0] mispredict_cnt
);

   localparam int IDX_BITS = $clog2(ENTRIES);

   // Counter encodings: reset value is weakly not-taken, allocation weakly taken.
   localparam logic [CNT_BITS-1:0] CNT_WEAK_NT = CNT_BITS'((2 ** (CNT_BITS - 1)) - 1);
   localparam logic [CNT_BITS-1:0] CNT_WEAK_T  = CNT_BITS'(2 ** (CNT_BITS - 1));
   localparam logic [CNT_BITS-1:0] CNT_MAX     = {CNT_BITS{1'b1}};
   localparam logic [CNT_BITS-1:0] CNT_ONE     = CNT_BITS'(1);

   // ---------------------------------------------------------------------------
   // Table state
   // ---------------------------------------------------------------------------
   logic                valid_q  [ENTRIES];
   logic                valid_d  [ENTRIES];
   logic [TAG_BITS-1:0] tag_q    [ENTRIES];
   logic [TAG_BITS-1:0] tag_d    [ENTRIES];
   logic [63:0]         target_q [ENTRIES];
   logic [63:0]         target_d [ENTRIES];
   logic                uncond_q [ENTRIES];
   logic                uncond_d [ENTRIES];
   logic [CNT_BITS-1:0] cnt_q    [ENTRIES];
   logic [CNT_BITS-1:0] cnt_d    [ENTRIES];
`ifdef BP_RAS_EN
   logic                ret_q    [ENTRIES];
   logic                ret_d    [ENTRIES];
`endif

   logic [31:0] misp_cnt_q;
   logic [31:0] misp_cnt_d;

`ifdef BP_RAS_EN
   localparam int RAS_PTR_BITS = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int RAS_CNT_BITS = RAS_PTR_BITS + 1;
   localparam logic [RAS_CNT_BITS-1:0] RAS_FULL = RAS_CNT_BITS'(RAS_DEPTH);

   // ras_ptr_q points at the next free slot; the top lives at ras_ptr_q-1.
   logic [63:0]             ras_q [RAS_DEPTH];
   logic [63:0]             ras_d [RAS_DEPTH];
   logic [RAS_PTR_BITS-1:0] ras_ptr_q;
   logic [RAS_PTR_BITS-1:0] ras_ptr_d;
   logic [RAS_CNT_BITS-1:0] ras_cnt_q;
   logic [RAS_CNT_BITS-1:0] ras_cnt_d;
   logic [63:0]             ras_top;
`endif

   // ---------------------------------------------------------------------------
   // Lookup (combinational, reads only registered state: no bypass)
   // ---------------------------------------------------------------------------
   logic [IDX_BITS-1:0] lk_idx;
   logic [TAG_BITS-1:0] lk_tag;
   logic                lk_hit;
   logic                lk_taken;
   logic [63:0]         lk_target;

   assign lk_idx = fetch_pc[IDX_BITS+1:2];
   assign lk_tag = fetch_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];

`ifdef BP_RAS_EN
   assign ras_top = ras_q[ras_ptr_q - RAS_PTR_BITS'(1)];
`endif

   always_comb begin
      lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
      lk_taken  = lk_hit && (uncond_q[lk_idx] || cnt_q[lk_idx][CNT_BITS-1]);
      lk_target = target_q[lk_idx];
`ifdef BP_RAS_EN
      if (ret_q[lk_idx] && (ras_cnt_q != '0)) begin
         lk_target = ras_top;
      end
`endif
      predict_pcsrc  = lk_taken;
      predict_target = lk_taken ? lk_target : (fetch_pc + 64'd4);
   end

   // ---------------------------------------------------------------------------
   // Training
   // ---------------------------------------------------------------------------
   logic [IDX_BITS-1:0] cm_idx;
   logic [TAG_BITS-1:0] cm_tag;
   logic                cm_hit;

   assign cm_idx = commit_pc[IDX_BITS+1:2];
   assign cm_tag = commit_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
   assign cm_hit = valid_q[cm_idx] && (tag_q[cm_idx] == cm_tag);

   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      uncond_d = uncond_q;
      cnt_d    = cnt_q;
`ifdef BP_RAS_EN
      ret_d    = ret_q;
`endif
      // Everything is gated by commit_valid so junk on commit_* is harmless.
      if (commit_valid) begin
         if (commit_pcsrc) begin
            target_d[cm_idx] = commit_target;
            uncond_d[cm_idx] = commit_uncond;
`ifdef BP_RAS_EN
            ret_d[cm_idx]    = commit_ret;
`endif
            if (cm_hit) begin
               if (cnt_q[cm_idx] != CNT_MAX) begin
                  cnt_d[cm_idx] = cnt_q[cm_idx] + CNT_ONE;
               end
            end else begin
               // Allocation simply overwrites whatever lived at this index.
               valid_d[cm_idx] = 1'b1;
               tag_d[cm_idx]   = cm_tag;
               cnt_d[cm_idx]   = CNT_WEAK_T;
            end
         end else if (cm_hit && (cnt_q[cm_idx] != '0)) begin
            cnt_d[cm_idx] = cnt_q[cm_idx] - CNT_ONE;
         end
      end
   end

   always_comb begin
      misp_cnt_d = misp_cnt_q;
      if (commit_valid && !commit_hit && (misp_cnt_q != 32'hFFFF_FFFF)) begin
         misp_cnt_d = misp_cnt_q + 32'd1;
      end
   end

`ifdef BP_RAS_EN
   // Pop is applied before push so a call+ret in one cycle replaces the top.
   // A push while full lands on the oldest slot, because the write pointer has
   // wrapped onto it; the occupancy then stays at RAS_DEPTH.
   always_comb begin
      ras_d     = ras_q;
      ras_ptr_d = ras_ptr_q;
      ras_cnt_d = ras_cnt_q;
      if (commit_valid) begin
         if (commit_ret && (ras_cnt_q != '0)) begin
            ras_ptr_d = ras_ptr_q - RAS_PTR_BITS'(1);
            ras_cnt_d = ras_cnt_q - RAS_CNT_BITS'(1);
         end
         if (commit_call) begin
            ras_d[ras_ptr_d] = commit_pc + 64'd4;
            ras_ptr_d        = ras_ptr_d + RAS_PTR_BITS'(1);
            if (ras_cnt_d != RAS_FULL) begin
               ras_cnt_d = ras_cnt_d + RAS_CNT_BITS'(1);
            end
         end
      end
   end
`else
   logic unused_commit;
   assign unused_commit = ^{commit_pc, commit_call, commit_ret};
`endif

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            uncond_q[i] <= 1'b0;
            cnt_q[i]    <= CNT_WEAK_NT;
`ifdef BP_RAS_EN
            ret_q[i]    <= 1'b0;
`endif
         end
         misp_cnt_q <= '0;
      end else begin
         valid_q    <= valid_d;
         tag_q      <= tag_d;
         target_q   <= target_d;
         uncond_q   <= uncond_d;
         cnt_q      <= cnt_d;
`ifdef BP_RAS_EN
         ret_q      <= ret_d;
`endif
         misp_cnt_q <= misp_cnt_d;
      end
   end

`ifdef BP_RAS_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < RAS_DEPTH; i++) begin
            ras_q[i] <= '0;
         end
         ras_ptr_q <= '0;
         ras_cnt_q <= '0;
      end else begin
         ras_q     <= ras_d;
         ras_ptr_q <= ras_ptr_d;
         ras_cnt_q <= ras_cnt_d;
      end
   end
`endif

   assign mispredict_cnt = misp_cnt_q;

endmodule

// File: doc/branch_predictor_bht.md
Name: branch_predictor_bht

Overview:
- Parametrised direction and target predictor sitting beside fetch.
- Provides same-cycle prediction (pcsrc plus target) for the fetch PC.
- Trains from decode-stage branch resolution commits (pc, actual pcsrc, target_pc, hit).
- Combines a direct-mapped BTB with per-entry saturating counters and keeps a mispredict statistic.

Parameters:
- ENTRIES, 64, number of BTB/BHT entries; power of two, ≥2; IDX_BITS = log2(ENTRIES).
- TAG_BITS, 12, PC tag bits stored per entry.
- CNT_BITS, 2, width of each saturating direction counter; ≥1.
- RAS_DEPTH, 8, return stack depth; power of two; used only with BP_RAS_EN.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- fetch_pc  in  64  PC being fetched
- predict_pcsrc  out  1  0=PCPLUS4, 1=PCJUMP
- predict_target  out  64  predicted next PC
- commit_valid  in  1  one resolved control-flow instruction this cycle
- commit_pc  in  64  PC of the resolved instruction
- commit_pcsrc  in  1  actual outcome, 0=PCPLUS4, 1=PCJUMP
- commit_target  in  64  actual target_pc when taken
- commit_uncond  in  1  JAL/JALR (always taken)
- commit_call  in  1  JAL/JALR with rd=x1 (RAS only)
- commit_ret  in  1  JALR rs1=x1, rd=x0 (RAS only)
- commit_hit  in  1  decode's bp_hit for this instruction
- mispredict_cnt  out  32  saturating count of commit_valid & !commit_hit

Behaviour:
- Index = pc[IDX_BITS+1:2]; tag = pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2].
- Entry fields: valid, tag, target[63:0], uncond, ret, cnt[CNT_BITS-1:0].
- Lookup is combinational from registered state, zero latency:
  - lhit = valid & tag match.
  - taken = lhit & (uncond | cnt[MSB]).
  - predict_pcsrc = taken.
  - predict_target = taken ? target : fetch_pc+4, wrapping mod 2^64.
- Update happens on the rising clk when commit_valid=1:
  - Actual PCJUMP with tag hit: target/uncond/ret rewritten; cnt increments, saturating at all-ones.
  - Actual PCJUMP with miss: entry allocated, overwriting any victim; valid=1, tag, target, uncond, ret set; cnt = 2^(CNT_BITS-1) (weakly taken).
  - Actual PCPLUS4 with tag hit: cnt decrements, saturating at 0; the entry stays valid.
  - Actual PCPLUS4 with miss: no table change.
- Same-cycle lookup and update to the same index: lookup returns the pre-update value; no bypass. The new value is visible from the next cycle.
- mispredict_cnt increments on commit_valid & !commit_hit and saturates at 0xFFFF_FFFF.
- Reset (resetn low, async):
  - All valid=0, cnt=2^(CNT_BITS-1)-1 (weakly not-taken), mispredict_cnt=0.
  - Outputs then read predict_pcsrc=0, predict_target=fetch_pc+4.
  - Reset asserted mid-update discards that update; state is reset immediately, independent of clk.
- X on commit_* while commit_valid=0 must not affect state.

Optional Feature:
- BP_RAS_EN defined: adds a RAS_DEPTH x 64 return stack with pointer and occupancy count.
  - Commit-time push of commit_pc+4 when commit_valid & commit_call.
  - Pop when commit_valid & commit_ret.
  - Both in one cycle: pop then push, so the top is replaced and the count is unchanged.
  - Push when full wraps and overwrites the oldest; the count stays RAS_DEPTH.
  - Pop when empty is ignored.
  - Lookup with lhit & ret & count>0 uses RAS top as predict_target; otherwise the BTB target is used.
  - Reset empties the stack.
- BP_RAS_EN undefined: no stack, ret field is unused, and commit_call/commit_ret are ignored.

Test Plan:
- Reset, fetch_pc=0x8000_0000 → predict_pcsrc=0, predict_target=0x8000_0004, mispredict_cnt=0.
- Commit BEQ pc=0x8000_0010 taken, target 0x8000_0100, hit=0 → next cycle fetch 0x8000_0010 predicts 1/0x8000_0100; mispredict_cnt=1.
- Same branch committed not-taken twice → cnt 2→1→0; predict_pcsrc=0, target 0x8000_0014. Third not-taken keeps cnt=0.
- JAL uncond at 0x8000_0020→0x8000_0400, then aliasing PC 0x8000_0020+4*ENTRIES with a different tag → no prediction for the alias until it is allocated. Allocation evicts the original.
- Commit an update to index i while fetching the same PC in that cycle → old prediction that cycle, new prediction the next cycle.
- BP_RAS_EN: commit call at 0x8000_0040, then ret entry at 0x8000_0500 trained → fetch 0x8000_0500 predicts 0x8000_0044. RAS_DEPTH+1 pushes then RAS_DEPTH+1 pops → the last pop is ignored.
